// File: rtl/counter_bank.sv
// rtl/counter_bank.sv - multi-channel counter/timer with shared prescaler on Avalon-MM
module counter_bank #(
  parameter int NUM_CH   = 4,
  parameter int WIDTH    = 32,
  parameter int PRESCALE = 1,
  parameter int ADDR_W   = 2 + $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              irq
);
  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [PS_W-1:0]  ps;
  logic             tick;
  logic [CH_W-1:0]  sel;
  logic [1:0]       reg_sel;
  logic [31:0]      rd_mux;

  logic [WIDTH-1:0] cnt [NUM_CH];
  logic [WIDTH-1:0] cmp [NUM_CH];
  logic [WIDTH-1:0] nxt [NUM_CH];
  logic [3:0]       ctrl [NUM_CH];
  logic [1:0]       stat [NUM_CH];

  logic [NUM_CH-1:0] wr_cnt, wr_cmp, wr_ctl, wr_st;
  logic [NUM_CH-1:0] adv, rld, set_m, set_o;

  generate
    if (NUM_CH > 1) begin : g_sel
      assign sel = address[ADDR_W-1:2];
    end else begin : g_sel_single
      assign sel = '0;
    end
  endgenerate

  assign reg_sel = address[1:0];
  assign tick    = (ps == PS_W'(PRESCALE - 1));

  // Tick-driven next values and flag events; a COUNT write suppresses this cycle's events.
  always_comb begin
    wr_cnt = '0;
    wr_cmp = '0;
    wr_ctl = '0;
    wr_st  = '0;
    adv    = '0;
    rld    = '0;
    set_m  = '0;
    set_o  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      nxt[c]    = '0;
      wr_cnt[c] = write && (sel == CH_W'(c)) && (reg_sel == 2'd0);
      wr_cmp[c] = write && (sel == CH_W'(c)) && (reg_sel == 2'd1);
      wr_ctl[c] = write && (sel == CH_W'(c)) && (reg_sel == 2'd2);
      wr_st[c]  = write && (sel == CH_W'(c)) && (reg_sel == 2'd3);
      adv[c]    = tick && ctrl[c][0];
      rld[c]    = ctrl[c][1] && (cnt[c] == cmp[c]);
      nxt[c]    = rld[c] ? '0 : cnt[c] + WIDTH'(1);
      set_m[c]  = adv[c] && !wr_cnt[c] && (nxt[c] == cmp[c]);
      set_o[c]  = adv[c] && !wr_cnt[c] && !rld[c] && (&cnt[c]);
    end
  end

  always_comb begin
    rd_mux = '0;
    case (reg_sel)
      2'd0:    rd_mux[WIDTH-1:0] = cnt[sel];
      2'd1:    rd_mux[WIDTH-1:0] = cmp[sel];
      2'd2:    rd_mux[3:0]       = ctrl[sel];
      default: rd_mux[1:0]       = stat[sel];
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ps       <= '0;
      readdata <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        cnt[c]  <= '0;
        cmp[c]  <= '1;
        ctrl[c] <= '0;
        stat[c] <= '0;
      end
    end else begin
      ps       <= tick ? '0 : ps + PS_W'(1);
      readdata <= read ? rd_mux : '0;
      for (int c = 0; c < NUM_CH; c++) begin
        if (wr_cnt[c])
          cnt[c] <= writedata[WIDTH-1:0];
        else if (adv[c])
          cnt[c] <= nxt[c];
        if (wr_cmp[c])
          cmp[c] <= writedata[WIDTH-1:0];
        // A CTRL write beats the one-shot auto-disable landing on the same edge.
        if (wr_ctl[c])
          ctrl[c] <= writedata[3:0];
        else if (set_m[c] && ctrl[c][3])
          ctrl[c][0] <= 1'b0;
        stat[c][0] <= set_m[c] | (stat[c][0] & ~(wr_st[c] & writedata[0]));
        stat[c][1] <= set_o[c] | (stat[c][1] & ~(wr_st[c] & writedata[1]));
      end
    end
  end

  always_comb begin
    irq = 1'b0;
    for (int c = 0; c < NUM_CH; c++)
      irq = irq | (stat[c][0] & ctrl[c][2]);
  end

endmodule

// File: tb/tb_counter_bank.sv
// tb/tb_counter_bank.sv - bench for counter_bank: 32-bit/prescale-1 and 8-bit/prescale-4 builds vs a model
module tb_counter_bank;
  localparam int NI = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [3:0]  address = '0;
  logic [31:0] writedata = '0;
  logic [31:0] rd0, rd1;
  logic        irq0, irq1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  counter_bank #(.NUM_CH(4), .WIDTH(32), .PRESCALE(1)) dut0 (
    .clk(clk), .reset_n(reset_n), .address(address), .read(read), .write(write),
    .writedata(writedata), .readdata(rd0), .irq(irq0)
  );

  counter_bank #(.NUM_CH(4), .WIDTH(8), .PRESCALE(4)) dut1 (
    .clk(clk), .reset_n(reset_n), .address(address), .read(read), .write(write),
    .writedata(writedata), .readdata(rd1), .irq(irq1)
  );

  // Behavioural model: one entry per instance, values kept as plain integers.
  int          mw [NI] = '{32, 8};
  int          mp [NI] = '{1, 4};
  longint      m_cnt [NI][4];
  longint      m_cmp [NI][4];
  bit          m_en [NI][4], m_rl [NI][4], m_ie [NI][4], m_os [NI][4];
  bit          m_mt [NI][4], m_ov [NI][4];
  int          m_ps [NI];
  logic [31:0] exp_rd [NI];
  bit          exp_irq [NI];

  task automatic model_step(input bit rstn, input bit rd, input bit wr, input int a, input logic [31:0] wd);
    longint top, n;
    int     ch, r;
    bit     tick, hit, sm, so;
    ch = a / 4;
    r  = a % 4;
    for (int i = 0; i < NI; i++) begin
      top = longint'(1) << mw[i];
      if (!rstn) begin
        m_ps[i]   = 0;
        exp_rd[i] = 0;
        for (int c = 0; c < 4; c++) begin
          m_cnt[i][c] = 0;
          m_cmp[i][c] = top - 1;
          m_en[i][c] = 0; m_rl[i][c] = 0; m_ie[i][c] = 0; m_os[i][c] = 0;
          m_mt[i][c] = 0; m_ov[i][c] = 0;
        end
      end else begin
        if (!rd)         exp_rd[i] = 0;
        else if (r == 0) exp_rd[i] = 32'(m_cnt[i][ch]);
        else if (r == 1) exp_rd[i] = 32'(m_cmp[i][ch]);
        else if (r == 2) exp_rd[i] = {28'd0, m_os[i][ch], m_ie[i][ch], m_rl[i][ch], m_en[i][ch]};
        else             exp_rd[i] = {30'd0, m_ov[i][ch], m_mt[i][ch]};
        tick    = (m_ps[i] == mp[i] - 1);
        m_ps[i] = (m_ps[i] + 1) % mp[i];
        for (int c = 0; c < 4; c++) begin
          hit = wr && (ch == c);
          sm  = 0;
          so  = 0;
          if (hit && r == 0) begin
            m_cnt[i][c] = longint'(wd) % top;
          end else if (tick && m_en[i][c]) begin
            if (m_rl[i][c] && m_cnt[i][c] == m_cmp[i][c]) begin
              n = 0;
            end else begin
              n  = (m_cnt[i][c] + 1) % top;
              so = (n == 0);
            end
            sm = (n == m_cmp[i][c]);
            m_cnt[i][c] = n;
            if (sm && m_os[i][c]) m_en[i][c] = 0;
          end
          if (hit && r == 1) m_cmp[i][c] = longint'(wd) % top;
          if (hit && r == 2) begin
            m_en[i][c] = wd[0]; m_rl[i][c] = wd[1]; m_ie[i][c] = wd[2]; m_os[i][c] = wd[3];
          end
          if (hit && r == 3) begin
            if (wd[0]) m_mt[i][c] = 0;
            if (wd[1]) m_ov[i][c] = 0;
          end
          if (sm) m_mt[i][c] = 1;
          if (so) m_ov[i][c] = 1;
        end
      end
      exp_irq[i] = 0;
      for (int c = 0; c < 4; c++) exp_irq[i] = exp_irq[i] | (m_mt[i][c] & m_ie[i][c]);
    end
  endtask

  task automatic bus(input bit rstn, input bit rd, input bit wr, input int a, input logic [31:0] wd);
    reset_n   = rstn;
    read      = rd;
    write     = wr;
    address   = a[3:0];
    writedata = wd;
    @(posedge clk);
    model_step(rstn, rd, wr, a, wd);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) bus(1, 0, 0, 0, 0);
  endtask

  task automatic wreg(input int a, input logic [31:0] d);
    bus(1, 0, 1, a, d);
  endtask

  task automatic rreg(input int a);
    bus(1, 1, 0, a, 0);
  endtask

  task automatic test_reset();
    logic [31:0] e0, e1;
    bus(0, 0, 0, 0, 0);
    bus(0, 0, 0, 0, 0);
    n_tests++;
    if (irq0 !== 1'b0 || irq1 !== 1'b0) begin
      n_fail++; $display("FAIL reset_irq got=%b/%b exp=0/0", irq0, irq1);
    end
    for (int a = 0; a < 16; a++) begin
      rreg(a);
      e0 = (a % 4 == 1) ? 32'hFFFF_FFFF : 32'd0;
      e1 = (a % 4 == 1) ? 32'h0000_00FF : 32'd0;
      n_tests++;
      if (rd0 !== e0 || rd1 !== e1) begin
        n_fail++; $display("FAIL reset_read a=%0d got=%h/%h exp=%h/%h", a, rd0, rd1, e0, e1);
      end
    end
    idle(1);
    n_tests++;
    if (rd0 !== 32'd0 || rd1 !== 32'd0) begin
      n_fail++; $display("FAIL reset_idle_readdata got=%h/%h exp=0/0", rd0, rd1);
    end
  endtask

  task automatic test_free_run();
    wreg(2, 32'h1);
    idle(10);
    rreg(0);
    n_tests++;
    if (rd0 !== 32'd10) begin
      n_fail++; $display("FAIL free_run_count0 got=%0d exp=10", rd0);
    end
    n_tests++;
    if (rd1 !== exp_rd[1]) begin
      n_fail++; $display("FAIL free_run_count0_ps4 got=%0d exp=%0d", rd1, exp_rd[1]);
    end
    for (int c = 1; c < 4; c++) begin
      rreg(c * 4);
      n_tests++;
      if (rd0 !== 32'd0 || rd1 !== 32'd0) begin
        n_fail++; $display("FAIL free_run_idle_ch%0d got=%h/%h exp=0/0", c, rd0, rd1);
      end
    end
  endtask

  task automatic test_autoreload();
    wreg(9, 32'd3);
    wreg(10, 32'h7);
    for (int k = 0; k < 6; k++) begin
      rreg(8);
      n_tests++;
      if (rd0 !== 32'(k % 4) || rd1 !== exp_rd[1]) begin
        n_fail++; $display("FAIL reload_seq k=%0d got=%0d/%0d exp=%0d/%0d", k, rd0, rd1, k % 4, exp_rd[1]);
      end
      n_tests++;
      if (irq0 !== (k >= 2) || irq1 !== exp_irq[1]) begin
        n_fail++; $display("FAIL reload_irq k=%0d got=%b/%b exp=%b/%b", k, irq0, irq1, k >= 2, exp_irq[1]);
      end
    end
    idle(1);
    wreg(11, 32'h1);
    n_tests++;
    if (irq0 !== 1'b0 || irq1 !== exp_irq[1]) begin
      n_fail++; $display("FAIL w1c_irq_low got=%b/%b exp=0/%b", irq0, irq1, exp_irq[1]);
    end
    idle(2);
    n_tests++;
    if (irq0 !== 1'b0) begin
      n_fail++; $display("FAIL w1c_irq_stays_low got=%b exp=0", irq0);
    end
    idle(1);
    n_tests++;
    if (irq0 !== 1'b1 || irq1 !== exp_irq[1]) begin
      n_fail++; $display("FAIL w1c_irq_reassert got=%b/%b exp=1/%b", irq0, irq1, exp_irq[1]);
    end
  endtask

  task automatic test_oneshot();
    wreg(10, 32'h0);
    wreg(5, 32'd5);
    wreg(6, 32'h9);
    idle(30);
    rreg(4);
    n_tests++;
    if (rd0 !== 32'd5 || rd1 !== 32'd5) begin
      n_fail++; $display("FAIL oneshot_count got=%0d/%0d exp=5/5", rd0, rd1);
    end
    rreg(6);
    n_tests++;
    if (rd0 !== 32'h8 || rd1 !== 32'h8) begin
      n_fail++; $display("FAIL oneshot_ctrl got=%h/%h exp=8/8", rd0, rd1);
    end
    rreg(7);
    n_tests++;
    if (rd0 !== 32'h1 || rd1 !== 32'h1) begin
      n_fail++; $display("FAIL oneshot_status got=%h/%h exp=1/1", rd0, rd1);
    end
    n_tests++;
    if (irq0 !== 1'b0 || irq1 !== 1'b0) begin
      n_fail++; $display("FAIL oneshot_irq got=%b/%b exp=0/0", irq0, irq1);
    end
  endtask

  task automatic test_overflow();
    wreg(2, 32'h0);
    wreg(1, 32'h10);
    wreg(0, 32'hFFFF_FFFE);
    wreg(3, 32'h3);
    wreg(2, 32'h1);
    idle(2);
    rreg(0);
    n_tests++;
    if (rd0 !== 32'd0 || rd1 !== exp_rd[1]) begin
      n_fail++; $display("FAIL ovf_count got=%h/%h exp=0/%h", rd0, rd1, exp_rd[1]);
    end
    rreg(3);
    n_tests++;
    if (rd0 !== 32'h2 || rd1 !== exp_rd[1]) begin
      n_fail++; $display("FAIL ovf_status got=%h/%h exp=2/%h", rd0, rd1, exp_rd[1]);
    end
    idle(10);
    rreg(3);
    n_tests++;
    if (rd1 !== 32'h2) begin
      n_fail++; $display("FAIL ovf_status_w8 got=%h exp=2", rd1);
    end
    wreg(0, 32'h55);
    rreg(0);
    n_tests++;
    if (rd0 !== 32'h55 || rd1 !== 32'h55) begin
      n_fail++; $display("FAIL count_write_vs_tick got=%h/%h exp=55/55", rd0, rd1);
    end
    wreg(3, 32'h3);
    wreg(0, 32'h10);
    rreg(3);
    n_tests++;
    if (rd0 !== 32'h0 || rd1 !== 32'h0) begin
      n_fail++; $display("FAIL count_write_no_flag got=%h/%h exp=0/0", rd0, rd1);
    end
  endtask

  task automatic test_prescale();
    logic [31:0] f0, f1;
    wreg(14, 32'h1);
    f0 = '0;
    f1 = '0;
    for (int k = 0; k < 17; k++) begin
      rreg(12);
      if (k == 0) begin
        f0 = rd0;
        f1 = rd1;
      end
      n_tests++;
      if (rd0 !== exp_rd[0] || rd1 !== exp_rd[1]) begin
        n_fail++; $display("FAIL prescale_read k=%0d got=%0d/%0d exp=%0d/%0d", k, rd0, rd1, exp_rd[0], exp_rd[1]);
      end
    end
    n_tests++;
    if (rd0 - f0 !== 32'd16 || rd1 - f1 !== 32'd4) begin
      n_fail++; $display("FAIL prescale_rate got=%0d/%0d exp=16/4", rd0 - f0, rd1 - f1);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] e0, e1;
    wreg(10, 32'h7);
    idle(6);
    n_tests++;
    if (irq0 !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset_irq got=%b exp=1", irq0);
    end
    bus(0, 1, 0, 8, 0);
    n_tests++;
    if (rd0 !== 32'd0 || rd1 !== 32'd0 || irq0 !== 1'b0 || irq1 !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset_outputs got=%h/%h irq=%b/%b exp=0/0 irq=0/0", rd0, rd1, irq0, irq1);
    end
    for (int a = 0; a < 16; a++) begin
      rreg(a);
      e0 = (a % 4 == 1) ? 32'hFFFF_FFFF : 32'd0;
      e1 = (a % 4 == 1) ? 32'h0000_00FF : 32'd0;
      n_tests++;
      if (rd0 !== e0 || rd1 !== e1) begin
        n_fail++; $display("FAIL mid_reset_read a=%0d got=%h/%h exp=%h/%h", a, rd0, rd1, e0, e1);
      end
    end
  endtask

  task automatic test_random();
    bit          rs, rd, wr;
    int          a;
    logic [31:0] wd;
    for (int k = 0; k < 400; k++) begin
      rs = ($urandom_range(0, 199) != 0);
      rd = $urandom_range(0, 1);
      wr = ($urandom_range(0, 9) < 4);
      a  = $urandom_range(0, 15);
      wd = $urandom_range(0, 1) ? 32'($urandom_range(0, 7)) : $urandom;
      if (a % 4 == 2) wd = 32'($urandom_range(0, 15));
      bus(rs, rd, wr, a, wd);
      n_tests++;
      if (rd0 !== exp_rd[0] || rd1 !== exp_rd[1]) begin
        n_fail++; $display("FAIL random_read k=%0d a=%0d got=%h/%h exp=%h/%h", k, a, rd0, rd1, exp_rd[0], exp_rd[1]);
      end
      n_tests++;
      if (irq0 !== exp_irq[0] || irq1 !== exp_irq[1]) begin
        n_fail++; $display("FAIL random_irq k=%0d got=%b/%b exp=%b/%b", k, irq0, irq1, exp_irq[0], exp_irq[1]);
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_free_run();
    test_autoreload();
    test_oneshot();
    test_overflow();
    test_prescale();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
